// File: rtl/i2c_seq_pkg.sv
// ---------------------------------------------------------------------------
// i2c_seq_pkg
// Shared definitions for the i2c register sequencer:
//   - state_t      : sequencer FSM encodings (IDLE / XFER / DONE)
//   - CMD_WRITE/READ: values of cmd_rw
//   - LEN_1/LEN_2  : values of cmd_len
//   - byte_total() : bytes on the wire per transaction (pointer + data)
// ---------------------------------------------------------------------------
package i2c_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic CMD_WRITE = 1'b0;
    localparam logic CMD_READ  = 1'b1;

    localparam logic LEN_1 = 1'b0;
    localparam logic LEN_2 = 1'b1;

    // Pointer byte plus one or two data bytes.
    function automatic logic [1:0] byte_total(input logic len);
        return (len == LEN_2) ? 2'd3 : 2'd2;
    endfunction

endpackage

// File: rtl/i2c_seq_watchdog.sv
// ---------------------------------------------------------------------------
// i2c_seq_watchdog
// Counts clk cycles while 'run' is high; 'clear' reloads the count to 0.
// 'expired' is asserted combinationally in the cycle the count sits at
// TIMEOUT_CYCLES-1 with run high and no clear, so the owner reacts on the
// following edge, exactly TIMEOUT_CYCLES cycles after the last clear.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   clear      : reload counter to 0
//   run        : count enable
//   expired    : timeout reached
// ---------------------------------------------------------------------------
module i2c_seq_watchdog #(
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (run && (cnt_q != LAST)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // An edge arriving in the final cycle still wins over the timeout.
    assign expired = run & ~clear & (cnt_q == LAST);

endmodule

// File: rtl/i2c_reg_sequencer.sv
// ---------------------------------------------------------------------------
// i2c_reg_sequencer
// Turns a single register command into the ena/rw/data_wr handshake of the
// byte-level i2c_master, counting busy rise/fall edges to step through the
// pointer byte and 1-2 data bytes, and returns a single rsp_valid pulse.
//   Write: [ptr][d0]([d1])            rw stays 0
//   Read : [ptr] Sr [d0]([d1])        rw set to 1 after the pointer starts
// Ports:
//   clk, reset                   : clock, synchronous active-high reset
//   cmd_valid/cmd_ready          : command handshake
//   cmd_rw, cmd_len, cmd_reg,
//   cmd_wdata                    : command fields
//   rsp_valid, rsp_data, rsp_err : one-cycle response
//   m_ena, m_addr, m_rw,
//   m_data_wr                    : to i2c_master
//   m_busy, m_data_rd,
//   m_ack_error                  : from i2c_master
// Optional: define I2C_SEQ_TIMEOUT_EN to add a watchdog that aborts a
// transaction after TIMEOUT_CYCLES cycles without a busy edge.
// ---------------------------------------------------------------------------
module i2c_reg_sequencer
    import i2c_seq_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR       = 7'h5A,
    parameter bit         LSB_FIRST      = 1'b1,
    parameter int         TIMEOUT_CYCLES = 200000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rw,
    input  logic        cmd_len,
    input  logic [7:0]  cmd_reg,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic        m_ena,
    output logic [6:0]  m_addr,
    output logic        m_rw,
    output logic [7:0]  m_data_wr,
    input  logic        m_busy,
    input  logic [7:0]  m_data_rd,
    input  logic        m_ack_error
);

    state_t      state_q;
    logic        busy_q;
    logic [1:0]  rise_cnt_q;
    logic [1:0]  fall_cnt_q;
    logic        rw_q;
    logic        len_q;
    logic [15:0] wdata_q;
    logic [15:0] rd_q;
    logic        err_q;
    logic        m_ena_q;
    logic        m_rw_q;
    logic [7:0]  m_data_wr_q;
    logic        rsp_valid_q;
    logic [15:0] rsp_data_q;
    logic        rsp_err_q;

    logic        rise;
    logic        fall;
    logic        accept;
    logic        timeout;
    logic [1:0]  total;
    logic [1:0]  rise_cnt_d;
    logic [1:0]  fall_cnt_d;
    logic [7:0]  wr_byte;
    logic        capture_hi;
    logic [15:0] rd_d;
    logic        err_d;

    assign rise      = m_busy & ~busy_q;
    assign fall      = ~m_busy & busy_q;
    assign cmd_ready = (state_q == IDLE) & ~m_busy;
    assign accept    = cmd_valid & cmd_ready;
    assign total     = byte_total(len_q);
    assign rise_cnt_d = rise_cnt_q + 2'd1;
    assign fall_cnt_d = fall_cnt_q + 2'd1;

    // Data byte to present after rise k (k = 1: first data byte, k = 2:
    // second). A single-byte command always uses the low byte.
    always_comb begin
        wr_byte = wdata_q[7:0];
        if (rise_cnt_d == 2'd1) begin
            wr_byte = (LSB_FIRST || (len_q == LEN_1)) ? wdata_q[7:0] : wdata_q[15:8];
        end else begin
            wr_byte = LSB_FIRST ? wdata_q[15:8] : wdata_q[7:0];
        end
    end

    // Read byte landing on fall j: j = 2 is the first data byte, j = 3 the
    // second. Mirrors the write-side byte ordering.
    always_comb begin
        capture_hi = 1'b0;
        if (fall_cnt_d == 2'd2) begin
            capture_hi = !LSB_FIRST && (len_q == LEN_2);
        end else begin
            capture_hi = LSB_FIRST;
        end
    end

    always_comb begin
        rd_d = rd_q;
        if ((state_q == XFER) && fall && (rw_q == CMD_READ) && (fall_cnt_d >= 2'd2)) begin
            if (capture_hi) begin
                rd_d[15:8] = m_data_rd;
            end else begin
                rd_d[7:0] = m_data_rd;
            end
        end
    end

    assign err_d = err_q | ((state_q == XFER) & m_ack_error);

`ifdef I2C_SEQ_TIMEOUT_EN
    logic wd_expired;

    i2c_seq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (accept | rise | fall),
        .run     (state_q == XFER),
        .expired (wd_expired)
    );

    assign timeout = wd_expired;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            rise_cnt_q  <= 2'd0;
            fall_cnt_q  <= 2'd0;
            rw_q        <= CMD_WRITE;
            len_q       <= LEN_1;
            wdata_q     <= 16'h0000;
            rd_q        <= 16'h0000;
            err_q       <= 1'b0;
            m_ena_q     <= 1'b0;
            m_rw_q      <= 1'b0;
            m_data_wr_q <= 8'h00;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 16'h0000;
            rsp_err_q   <= 1'b0;
        end else begin
            busy_q      <= m_busy;
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        rw_q        <= cmd_rw;
                        len_q       <= cmd_len;
                        wdata_q     <= cmd_wdata;
                        rd_q        <= 16'h0000;
                        err_q       <= 1'b0;
                        rise_cnt_q  <= 2'd0;
                        fall_cnt_q  <= 2'd0;
                        m_ena_q     <= 1'b1;
                        m_rw_q      <= 1'b0;
                        m_data_wr_q <= cmd_reg;
                        state_q     <= XFER;
                    end
                end
                XFER: begin
                    err_q <= err_d;
                    rd_q  <= rd_d;
                    if (timeout) begin
                        m_ena_q     <= 1'b0;
                        err_q       <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_data_q  <= rd_d;
                        state_q     <= DONE;
                    end else if (rise) begin
                        rise_cnt_q <= rise_cnt_d;
                        if (rise_cnt_d == total) begin
                            // Master has latched the last byte; no more to queue.
                            m_ena_q <= 1'b0;
                        end else if (rw_q == CMD_WRITE) begin
                            m_data_wr_q <= wr_byte;
                        end else begin
                            // Pointer byte is underway; the next byte is a read,
                            // which the master turns into a repeated start.
                            m_rw_q <= 1'b1;
                        end
                    end else if (fall) begin
                        fall_cnt_q <= fall_cnt_d;
                        if (fall_cnt_d == total) begin
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= err_d;
                            rsp_data_q  <= rd_d;
                            state_q     <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign m_addr    = DEV_ADDR;
    assign m_ena     = m_ena_q;
    assign m_rw      = m_rw_q;
    assign m_data_wr = m_data_wr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// ---------------------------------------------------------------------------
// tb_i2c_reg_sequencer
// Two sequencers share all inputs: dut_a uses LSB_FIRST = 1, dut_b uses
// LSB_FIRST = 0. The bench plays the i2c_master by hand, raising and
// dropping busy one byte at a time.
// ---------------------------------------------------------------------------
module tb_i2c_reg_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_rw;
    logic        cmd_len;
    logic [7:0]  cmd_reg;
    logic [15:0] cmd_wdata;
    logic        m_busy;
    logic [7:0]  m_data_rd;
    logic        m_ack_error;

    logic        a_cmd_ready, b_cmd_ready;
    logic        a_rsp_valid, b_rsp_valid;
    logic [15:0] a_rsp_data,  b_rsp_data;
    logic        a_rsp_err,   b_rsp_err;
    logic        a_m_ena,     b_m_ena;
    logic [6:0]  a_m_addr,    b_m_addr;
    logic        a_m_rw,      b_m_rw;
    logic [7:0]  a_m_data_wr, b_m_data_wr;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    i2c_reg_sequencer #(.DEV_ADDR(7'h5A), .LSB_FIRST(1'b1), .TIMEOUT_CYCLES(1000)) dut_a (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(a_cmd_ready),
        .cmd_rw(cmd_rw), .cmd_len(cmd_len), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
        .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data), .rsp_err(a_rsp_err),
        .m_ena(a_m_ena), .m_addr(a_m_addr), .m_rw(a_m_rw), .m_data_wr(a_m_data_wr),
        .m_busy(m_busy), .m_data_rd(m_data_rd), .m_ack_error(m_ack_error)
    );

    i2c_reg_sequencer #(.DEV_ADDR(7'h5A), .LSB_FIRST(1'b0), .TIMEOUT_CYCLES(1000)) dut_b (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(b_cmd_ready),
        .cmd_rw(cmd_rw), .cmd_len(cmd_len), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
        .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .rsp_err(b_rsp_err),
        .m_ena(b_m_ena), .m_addr(b_m_addr), .m_rw(b_m_rw), .m_data_wr(b_m_data_wr),
        .m_busy(m_busy), .m_data_rd(m_data_rd), .m_ack_error(m_ack_error)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic busy_rise();
        m_busy = 1'b1;
        tick();
    endtask

    task automatic busy_fall(input logic [7:0] d);
        m_data_rd = d;
        m_busy    = 1'b0;
        tick();
    endtask

    task automatic issue(input logic rw, input logic len, input logic [7:0] r, input logic [15:0] wd);
        cmd_rw    = rw;
        cmd_len   = len;
        cmd_reg   = r;
        cmd_wdata = wd;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_len = 1'b0;
        cmd_reg = 8'h00; cmd_wdata = 16'h0000; m_busy = 1'b0;
        m_data_rd = 8'h00; m_ack_error = 1'b0;
        ticks(3);
        reset = 1'b0;
        tick();
        tests++; if (a_m_ena !== 1'b0) begin fails++; $display("FAIL rst_m_ena: got %b want 0", a_m_ena); end
        tests++; if (a_m_rw !== 1'b0) begin fails++; $display("FAIL rst_m_rw: got %b want 0", a_m_rw); end
        tests++; if (a_m_data_wr !== 8'h00) begin fails++; $display("FAIL rst_m_data_wr: got %h want 00", a_m_data_wr); end
        tests++; if (a_m_addr !== 7'h5A) begin fails++; $display("FAIL rst_m_addr: got %h want 5a", a_m_addr); end
        tests++; if ({a_rsp_valid, a_rsp_err, a_rsp_data} !== 18'h0) begin fails++; $display("FAIL rst_rsp: got v=%b e=%b d=%h want 0/0/0000", a_rsp_valid, a_rsp_err, a_rsp_data); end
        tests++; if (a_cmd_ready !== 1'b1) begin fails++; $display("FAIL rst_cmd_ready: got %b want 1", a_cmd_ready); end
        $display("[TB] reset checked");
    endtask

    task automatic test_write_1byte();
        issue(1'b0, 1'b0, 8'h07, 16'h00A6);
        tests++; if (a_m_ena !== 1'b1 || a_m_data_wr !== 8'h07) begin fails++; $display("FAIL w1_accept: got ena=%b d=%h want 1/07", a_m_ena, a_m_data_wr); end
        tick();
        busy_rise();
        tests++; if (a_m_data_wr !== 8'hA6 || b_m_data_wr !== 8'hA6) begin fails++; $display("FAIL w1_byte1: got a=%h b=%h want a6/a6", a_m_data_wr, b_m_data_wr); end
        tests++; if (a_m_rw !== 1'b0 || a_m_ena !== 1'b1) begin fails++; $display("FAIL w1_rise1_ctl: got rw=%b ena=%b want 0/1", a_m_rw, a_m_ena); end
        ticks(2);
        busy_fall(8'h00);
        tests++; if (a_rsp_valid !== 1'b0) begin fails++; $display("FAIL w1_early_rsp: got %b want 0", a_rsp_valid); end
        tick();
        busy_rise();
        tests++; if (a_m_ena !== 1'b0 || a_m_rw !== 1'b0) begin fails++; $display("FAIL w1_rise2: got ena=%b rw=%b want 0/0", a_m_ena, a_m_rw); end
        ticks(2);
        busy_fall(8'h00);
        tests++; if (a_rsp_valid !== 1'b1 || a_rsp_err !== 1'b0) begin fails++; $display("FAIL w1_rsp: got v=%b e=%b want 1/0", a_rsp_valid, a_rsp_err); end
        tick();
        tests++; if (a_rsp_valid !== 1'b0) begin fails++; $display("FAIL w1_rsp_pulse: got %b want 0", a_rsp_valid); end
        $display("[TB] write 1 byte reg=07 data=a6 done");
    endtask

    task automatic test_read_2byte();
        issue(1'b1, 1'b1, 8'h07, 16'h0000);
        tests++; if (a_m_rw !== 1'b0 || a_m_data_wr !== 8'h07) begin fails++; $display("FAIL r2_accept: got rw=%b d=%h want 0/07", a_m_rw, a_m_data_wr); end
        tick();
        busy_rise();
        tests++; if (a_m_rw !== 1'b1 || a_m_ena !== 1'b1) begin fails++; $display("FAIL r2_rise1: got rw=%b ena=%b want 1/1", a_m_rw, a_m_ena); end
        ticks(2);
        busy_fall(8'hEE);
        tick();
        busy_rise();
        tests++; if (a_m_rw !== 1'b1 || a_m_ena !== 1'b1) begin fails++; $display("FAIL r2_rise2: got rw=%b ena=%b want 1/1", a_m_rw, a_m_ena); end
        ticks(2);
        busy_fall(8'h34);
        tick();
        busy_rise();
        tests++; if (a_m_ena !== 1'b0 || b_m_ena !== 1'b0) begin fails++; $display("FAIL r2_rise3_ena: got a=%b b=%b want 0/0", a_m_ena, b_m_ena); end
        ticks(2);
        busy_fall(8'h12);
        tests++; if (a_rsp_valid !== 1'b1 || a_rsp_data !== 16'h1234 || a_rsp_err !== 1'b0) begin fails++; $display("FAIL r2_rsp_lsb: got v=%b d=%h e=%b want 1/1234/0", a_rsp_valid, a_rsp_data, a_rsp_err); end
        tests++; if (b_rsp_valid !== 1'b1 || b_rsp_data !== 16'h3412) begin fails++; $display("FAIL r2_rsp_msb: got v=%b d=%h want 1/3412", b_rsp_valid, b_rsp_data); end
        ticks(3);
        tests++; if (a_rsp_data !== 16'h1234) begin fails++; $display("FAIL r2_hold: got %h want 1234", a_rsp_data); end
        $display("[TB] read 2 bytes reg=07 lsb=%h msb=%h", a_rsp_data, b_rsp_data);
    endtask

    task automatic test_write_nack();
        issue(1'b0, 1'b1, 8'h10, 16'hBEEF);
        tick();
        busy_rise();
        tests++; if (a_m_data_wr !== 8'hEF || b_m_data_wr !== 8'hBE) begin fails++; $display("FAIL wn_byte1: got a=%h b=%h want ef/be", a_m_data_wr, b_m_data_wr); end
        tick();
        busy_fall(8'h00);
        tick();
        busy_rise();
        tests++; if (a_m_data_wr !== 8'hBE || b_m_data_wr !== 8'hEF || a_m_ena !== 1'b1) begin fails++; $display("FAIL wn_byte2: got a=%h b=%h ena=%b want be/ef/1", a_m_data_wr, b_m_data_wr, a_m_ena); end
        m_ack_error = 1'b1;
        tick();
        m_ack_error = 1'b0;
        tick();
        busy_fall(8'h00);
        tests++; if (a_rsp_valid !== 1'b0) begin fails++; $display("FAIL wn_no_abort: got %b want 0", a_rsp_valid); end
        tick();
        busy_rise();
        tests++; if (a_m_ena !== 1'b0) begin fails++; $display("FAIL wn_rise3: got ena=%b want 0", a_m_ena); end
        tick();
        busy_fall(8'h00);
        tests++; if (a_rsp_valid !== 1'b1 || a_rsp_err !== 1'b1 || a_rsp_data !== 16'h0000) begin fails++; $display("FAIL wn_rsp: got v=%b e=%b d=%h want 1/1/0000", a_rsp_valid, a_rsp_err, a_rsp_data); end
        ticks(2);
        $display("[TB] write 2 bytes with nack rsp_err=%b", a_rsp_err);
    endtask

    task automatic test_busy_block();
        m_busy    = 1'b1;
        cmd_rw    = 1'b0; cmd_len = 1'b0; cmd_reg = 8'h3C; cmd_wdata = 16'h0099;
        cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (a_cmd_ready !== 1'b0 || a_m_ena !== 1'b0) begin fails++; $display("FAIL bb_blocked%0d: got rdy=%b ena=%b want 0/0", i, a_cmd_ready, a_m_ena); end
        end
        m_busy = 1'b0;
        #1;
        tests++; if (a_cmd_ready !== 1'b1) begin fails++; $display("FAIL bb_ready: got %b want 1", a_cmd_ready); end
        tick();
        cmd_valid = 1'b0;
        tests++; if (a_m_ena !== 1'b1 || a_m_data_wr !== 8'h3C) begin fails++; $display("FAIL bb_accept: got ena=%b d=%h want 1/3c", a_m_ena, a_m_data_wr); end
        tick();
        busy_rise();
        tick();
        busy_fall(8'h00);
        tick();
        busy_rise();
        tick();
        busy_fall(8'h00);
        tests++; if (a_rsp_valid !== 1'b1 || a_rsp_err !== 1'b0) begin fails++; $display("FAIL bb_rsp: got v=%b e=%b want 1/0", a_rsp_valid, a_rsp_err); end
        ticks(2);
        $display("[TB] command held while busy accepted after busy low");
    endtask

`ifdef I2C_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        issue(1'b0, 1'b0, 8'h44, 16'h0011);
        tick();
        busy_rise();
        ticks(999);
        tests++; if (a_rsp_valid !== 1'b0 || a_m_ena !== 1'b1) begin fails++; $display("FAIL to_early: got v=%b ena=%b want 0/1", a_rsp_valid, a_m_ena); end
        tick();
        tests++; if (a_rsp_valid !== 1'b1 || a_rsp_err !== 1'b1 || a_m_ena !== 1'b0) begin fails++; $display("FAIL to_fire: got v=%b e=%b ena=%b want 1/1/0", a_rsp_valid, a_rsp_err, a_m_ena); end
        m_busy = 1'b0;
        ticks(3);
        $display("[TB] timeout after 1000 cycles rsp_err=%b", a_rsp_err);
    endtask
`endif

    task automatic test_reset_mid_read();
        issue(1'b1, 1'b1, 8'h07, 16'h0000);
        tick();
        busy_rise();
        tick();
        busy_fall(8'hEE);
        tick();
        busy_rise();
        tick();
        reset  = 1'b1;
        m_busy = 1'b0;
        tick();
        tests++; if (a_m_ena !== 1'b0 || a_m_rw !== 1'b0 || a_m_data_wr !== 8'h00 || a_m_addr !== 7'h5A) begin fails++; $display("FAIL rm_mst: got ena=%b rw=%b d=%h a=%h want 0/0/00/5a", a_m_ena, a_m_rw, a_m_data_wr, a_m_addr); end
        tests++; if ({a_rsp_valid, a_rsp_err, a_rsp_data} !== 18'h0) begin fails++; $display("FAIL rm_rsp: got v=%b e=%b d=%h want 0/0/0000", a_rsp_valid, a_rsp_err, a_rsp_data); end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++; if (a_rsp_valid !== 1'b0) begin fails++; $display("FAIL rm_spurious%0d: got %b want 0", i, a_rsp_valid); end
        end
        issue(1'b0, 1'b0, 8'h22, 16'h0055);
        tests++; if (a_m_data_wr !== 8'h22 || a_m_ena !== 1'b1) begin fails++; $display("FAIL rm_new_accept: got d=%h ena=%b want 22/1", a_m_data_wr, a_m_ena); end
        tick();
        busy_rise();
        tests++; if (a_m_data_wr !== 8'h55) begin fails++; $display("FAIL rm_new_byte: got %h want 55", a_m_data_wr); end
        tick();
        busy_fall(8'h00);
        tick();
        busy_rise();
        tick();
        busy_fall(8'h00);
        tests++; if (a_rsp_valid !== 1'b1 || a_rsp_err !== 1'b0) begin fails++; $display("FAIL rm_new_rsp: got v=%b e=%b want 1/0", a_rsp_valid, a_rsp_err); end
        ticks(2);
        $display("[TB] reset mid-read then new write done");
    endtask

    initial begin
        test_reset();
        test_write_1byte();
        test_read_2byte();
        test_write_nack();
        test_busy_block();
`ifdef I2C_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
